// File: rtl/comment_strip.sv
// comment_strip: character filter that replaces C/C++ comments with spaces.
// Latency is fixed at two cycles and byte count is preserved. Substituted
// characters are flagged on out_is_sub.
// Optional feature macro: COMMENT_STRIP_STRING_EN. When it is defined, the
// filter tracks "..." string literals so that comment openers inside them
// are ignored.
module comment_strip #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  output logic [7:0]       out,
  output logic             out_is_sub,
  output logic [CNT_W-1:0] comment_cnt
);

  localparam logic [7:0] CH_SLASH  = 8'h2F;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_NL     = 8'h0A;
  localparam logic [7:0] CH_SPACE  = 8'h20;
`ifdef COMMENT_STRIP_STRING_EN
  localparam logic [7:0] CH_QUOTE  = 8'h22;
  localparam logic [7:0] CH_BSLASH = 8'h5C;
`endif

  typedef enum logic [2:0] {
    S_CODE    = 3'd0,
    S_SLASH   = 3'd1,
    S_LINE    = 3'd2,
    S_BLOCK   = 3'd3,
    S_BSTAR   = 3'd4
`ifdef COMMENT_STRIP_STRING_EN
    ,
    S_STR     = 3'd5,
    S_STR_ESC = 3'd6
`endif
  } state_e;

  typedef enum logic [1:0] {
    TAG_LIT   = 2'd0,
    TAG_SUB   = 2'd1,
    TAG_MAYBE = 2'd2
  } tag_e;

  state_e           state_q, state_d;
  tag_e             tag_q, tag_d;
  logic [7:0]       pend_char_q, pend_char_d;
  logic [7:0]       out_q, out_d;
  logic             sub_q, sub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             open_s;

  // Classify the incoming character against the current comment state.
  always_comb begin
    state_d     = state_q;
    tag_d       = TAG_LIT;
    open_s      = 1'b0;
    pend_char_d = in;
    case (state_q)
      S_CODE: begin
        if (in == CH_SLASH) begin
          state_d = S_SLASH;
          tag_d   = TAG_MAYBE;
`ifdef COMMENT_STRIP_STRING_EN
        end else if (in == CH_QUOTE) begin
          state_d = S_STR;
          tag_d   = TAG_LIT;
`endif
        end else begin
          state_d = S_CODE;
          tag_d   = TAG_LIT;
        end
      end
      S_SLASH: begin
        if (in == CH_SLASH) begin
          state_d = S_LINE;
          tag_d   = TAG_SUB;
          open_s  = 1'b1;
        end else if (in == CH_STAR) begin
          state_d = S_BLOCK;
          tag_d   = TAG_SUB;
          open_s  = 1'b1;
        end else begin
          state_d = S_CODE;
          tag_d   = TAG_LIT;
        end
      end
      S_LINE: begin
        if (in == CH_NL) begin
          state_d = S_CODE;
          tag_d   = TAG_LIT;
        end else begin
          state_d = S_LINE;
          tag_d   = TAG_SUB;
        end
      end
      S_BLOCK: begin
        tag_d = TAG_SUB;
        if (in == CH_STAR) begin
          state_d = S_BSTAR;
        end else begin
          state_d = S_BLOCK;
        end
      end
      S_BSTAR: begin
        tag_d = TAG_SUB;
        if (in == CH_SLASH) begin
          state_d = S_CODE;
        end else if (in == CH_STAR) begin
          state_d = S_BSTAR;
        end else begin
          state_d = S_BLOCK;
        end
      end
`ifdef COMMENT_STRIP_STRING_EN
      S_STR: begin
        tag_d = TAG_LIT;
        if (in == CH_BSLASH) begin
          state_d = S_STR_ESC;
        end else if ((in == CH_QUOTE) || (in == CH_NL)) begin
          state_d = S_CODE;
        end else begin
          state_d = S_STR;
        end
      end
      S_STR_ESC: begin
        tag_d   = TAG_LIT;
        state_d = S_STR;
      end
`endif
      default: begin
        state_d = S_CODE;
        tag_d   = TAG_LIT;
      end
    endcase
  end

  // Resolve the pending character now that its successor is visible.
  always_comb begin
    out_d = CH_SPACE;
    sub_d = 1'b0;
    case (tag_q)
      TAG_LIT: begin
        out_d = pend_char_q;
        sub_d = 1'b0;
      end
      TAG_SUB: begin
        out_d = CH_SPACE;
        sub_d = 1'b1;
      end
      TAG_MAYBE: begin
        if ((in == CH_SLASH) || (in == CH_STAR)) begin
          out_d = CH_SPACE;
          sub_d = 1'b1;
        end else begin
          out_d = pend_char_q;
          sub_d = 1'b0;
        end
      end
      default: begin
        out_d = pend_char_q;
        sub_d = 1'b0;
      end
    endcase
  end

  // Saturating count of recognised comment openers.
  always_comb begin
    if (open_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, pending lookahead and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_CODE;
      tag_q       <= TAG_LIT;
      pend_char_q <= CH_SPACE;
      out_q       <= CH_SPACE;
      sub_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      pend_char_q <= pend_char_d;
      out_q       <= out_d;
      sub_q       <= sub_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out         = out_q;
  assign out_is_sub  = sub_q;
  assign comment_cnt = cnt_q;

endmodule

// File: tb/tb_comment_strip.sv
// Directed testbench for comment_strip with hand-written output masks.
module tb_comment_strip;

  logic        clk;
  logic        reset;
  logic [7:0]  in;
  logic [7:0]  out;
  logic        out_is_sub;
  logic [15:0] comment_cnt;
  logic [7:0]  sat_out;
  logic        sat_sub;
  logic [2:0]  sat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  comment_strip #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in(in),
    .out(out), .out_is_sub(out_is_sub), .comment_cnt(comment_cnt)
  );

  // Narrow-counter instance used to reach saturation quickly.
  comment_strip #(.CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .in(in),
    .out(sat_out), .out_is_sub(sat_sub), .comment_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Assert reset between clock edges, check its asynchronous effect, hold, release.
  task automatic do_reset(input string name);
    #2;
    reset = 1'b0;
    in    = 8'h41;
    #1;
    check_eq({name, ".rst_async_out"}, 32'(out), 32'h20);
    check_eq({name, ".rst_async_sub"}, 32'(out_is_sub), 32'h0);
    check_eq({name, ".rst_async_cnt"}, 32'(comment_cnt), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_eq({name, ".rst_hold_out"}, 32'(out), 32'h20);
    reset = 1'b1;
  endtask

  // Stream s; mask m gives 'L' (literal) or 'S' (substituted) per character.
  task automatic run(input string name, input string s, input string m);
    logic [7:0] c;
    logic [7:0] mk;
    for (int i = 0; i <= s.len(); i++) begin
      in = (i < s.len()) ? s[i] : 8'h20;
      @(posedge clk);
      #1;
      if (i >= 1) begin
        c  = s[i-1];
        mk = m[i-1];
        if (mk == 8'h53) begin
          check_eq($sformatf("%s[%0d].out", name, i-1), 32'(out), 32'h20);
          check_eq($sformatf("%s[%0d].sub", name, i-1), 32'(out_is_sub), 32'h1);
        end else begin
          check_eq($sformatf("%s[%0d].out", name, i-1), 32'(out), 32'(c));
          check_eq($sformatf("%s[%0d].sub", name, i-1), 32'(out_is_sub), 32'h0);
        end
      end
    end
  endtask

  initial begin
    string s;
    string m;
    string line_s;
    string str_s;
    string nl2_s;
    line_s = $sformatf("a//z;%cc;", 8'h0A);
    str_s  = $sformatf("%ca//%c%cb%c;", 8'h22, 8'h5C, 8'h22, 8'h22);
    nl2_s  = $sformatf("//%c//%c", 8'h0A, 8'h0A);
    reset = 1'b0;
    in    = 8'h20;
    @(posedge clk);
    #1;

    do_reset("plain");
    run("plain", "int a;", "LLLLLL");
    check_eq("plain.cnt", 32'(comment_cnt), 32'd0);

    do_reset("block");
    run("block", "int /*x*/ b;", "LLLLSSSSSLLL");
    check_eq("block.cnt", 32'(comment_cnt), 32'd1);

    do_reset("line");
    run("line", line_s, "LSSSSLLL");
    check_eq("line.cnt", 32'(comment_cnt), 32'd1);

    do_reset("slashes");
    run("slashes", "/ / /x a/", "LLLLLLLLL");
    check_eq("slashes.cnt", 32'(comment_cnt), 32'd0);

    do_reset("noclose");
    run("noclose", "/*/ ; **/;", "SSSSSSSSSL");
    check_eq("noclose.cnt", 32'(comment_cnt), 32'd1);

    do_reset("reopen");
    run("reopen", "/**//x", "SSSSLL");
    check_eq("reopen.cnt", 32'(comment_cnt), 32'd1);

    do_reset("nonest");
    run("nonest", "/*//*/;", "SSSSSSL");
    check_eq("nonest.cnt", 32'(comment_cnt), 32'd1);

    do_reset("midrst");
    run("midrst", "/*ab", "SSSS");
    check_eq("midrst.cnt", 32'(comment_cnt), 32'd1);
    do_reset("midrst2");
    run("midrst2", ";", "L");
    check_eq("midrst2.cnt", 32'(comment_cnt), 32'd0);

    do_reset("string");
`ifdef COMMENT_STRIP_STRING_EN
    run("string", str_s, "LLLLLLLLL");
    check_eq("string.cnt", 32'(comment_cnt), 32'd0);
`else
    run("string", str_s, "LLSSSSSSS");
    check_eq("string.cnt", 32'(comment_cnt), 32'd1);
`endif

    do_reset("sat");
    s = "";
    m = "";
    for (int k = 0; k < 7; k++) begin
      s = {s, $sformatf("//%c", 8'h0A)};
      m = {m, "SSL"};
    end
    run("sat", s, m);
    check_eq("sat.cnt7", 32'(comment_cnt), 32'd7);
    check_eq("sat.narrow7", 32'(sat_cnt), 32'd7);
    run("sat2", nl2_s, "SSLSSL");
    check_eq("sat.cnt9", 32'(comment_cnt), 32'd9);
    check_eq("sat.narrow_hold", 32'(sat_cnt), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/comment_strip.md
Name: comment_strip

Overview:
- Front-end character filter that sits directly upstream of the int-declaration checker.
- Consumes one ASCII character per clock and removes C/C++ comments: line comments run from `//` to newline, block comments from `/*` to `*/`.
- Emits a cleaned stream, one character per clock, with a fixed latency of 2 cycles. Every removed character, including the comment delimiters, is replaced by a space (8'h20).
- Byte count and timing are preserved, so the downstream checker needs no valid handshake.

Parameters:
- CNT_W, 16, width of the saturating comment counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in  input  8  raw ASCII character, one new character every cycle.
- out  output  8  cleaned character, corresponding to `in` from 2 cycles earlier.
- out_is_sub  output  1  1 when `out` is a substituted space (the character was part of a comment).
- comment_cnt  output  CNT_W  number of comment openers recognised since reset; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous):
  - out=8'h20, out_is_sub=0, comment_cnt=0.
  - Pending register holds a space tagged literal; FSM returns to CODE.
  - Any comment that is open when reset asserts is abandoned.
- Latency:
  - Character c_k arriving in cycle k appears on out during cycle k+2.
  - One character of lookahead is held in a pending register {char, tag}; tag is one of LIT, SUB, MAYBE.
- Every edge does two things:
  - out <= resolve(pending, in).
  - pending <= classify(in, state).
- resolve rules:
  - MAYBE resolves to SUB when `in` is '/' or '*', otherwise to LIT.
  - LIT outputs the stored char with out_is_sub=0.
  - SUB outputs 8'h20 with out_is_sub=1.
- FSM states, with transitions driven by `in` each cycle:
  - CODE:
    - '/' goes to SLASH; the pending tag is MAYBE.
    - Any other character stays in CODE, tagged LIT.
  - SLASH:
    - '/' goes to LINE and is tagged SUB; comment_cnt increments.
    - '*' goes to BLOCK and is tagged SUB; comment_cnt increments.
    - Another '/' cannot occur here because it is the line-comment case above.
    - Any other character goes to CODE, tagged LIT (the held '/' resolves LIT).
  - LINE:
    - Newline (8'h0A) goes to CODE. The newline itself is tagged LIT and passed through.
    - Any other character stays in LINE, tagged SUB.
  - BLOCK:
    - '*' goes to BSTAR, tagged SUB.
    - Any other character stays in BLOCK, tagged SUB.
  - BSTAR:
    - '/' goes to CODE, tagged SUB (comment closed).
    - '*' stays in BSTAR, tagged SUB.
    - Any other character goes to BLOCK, tagged SUB.
- Boundary conditions:
  - `/*/` does not close: the opener '*' never counts as a closer.
  - `**/` closes.
  - `*//` closes, then the trailing '/' enters SLASH.
  - `/ /` is two literal slashes.
  - Inside BLOCK, `//` and `/*` have no effect; comments do not nest.
  - ';' and whitespace inside a comment are substituted like any other character.
  - An unterminated block comment continues indefinitely and is cleared only by reset.
  - comment_cnt holds at 2^CNT_W-1 once it saturates.
  - Reset deasserting mid-stream: the first character after deassertion is treated as starting in CODE.

Optional Feature:
- Macro: COMMENT_STRIP_STRING_EN.
- With the macro defined, two extra states are added: STR and STR_ESC.
  - CODE on '"' (8'h22) goes to STR.
  - In STR, all characters are LIT and comment openers are ignored.
  - In STR, '\' (8'h5C) goes to STR_ESC; the next character returns to STR unconditionally.
  - In STR, '"' returns to CODE.
  - A newline in STR returns to CODE, so an unterminated string is closed at end of line.
- Without the macro, '"' is an ordinary LIT character and comment detection also applies inside quotes.

Test Plan:
- Reset low for 3 cycles, then stream `int a;` -> out stays 8'h20 during reset; from cycle 2 after deassertion, out reproduces `int a;` exactly with out_is_sub=0; comment_cnt=0.
- Stream `int /*x*/ b;` -> out = `int ` followed by five 8'h20 characters with out_is_sub=1, then ` b;`; comment_cnt=1.
- Stream `a//z;` then 8'h0A then `c;` -> out = `a`, four SUB spaces, 8'h0A (LIT), `c;`; comment_cnt=1.
- Stream `/ /` and `/x` -> all characters are LIT; comment_cnt=0.
- Stream `/*/ ; **/;` -> everything through the closing `*/` is SUB, the final `;` is LIT; comment_cnt=1. Assert reset mid-comment in a second run -> FSM returns to CODE and the following `;` comes out LIT.
- With COMMENT_STRIP_STRING_EN: stream `"a//\"b";` -> every character is LIT and comment_cnt=0. Without the macro, the same stream gives comment_cnt=1 and SUB output from `//` onward.
